// File: rtl/vga_data_chk_if.sv
// Read-port bundle between the frame pattern checker (master) and the SDRAM
// arbiter read port (slave).
interface vga_data_chk_if;
    logic        rd_req;
    logic        rd_rdy;
    logic [15:0] din;
    logic        din_vld;

    modport master (output rd_req, input rd_rdy, input din, input din_vld);
    modport slave  (input rd_req, output rd_rdy, output din, output din_vld);
endinterface

// File: rtl/vga_data_chk.sv
// Frame-buffer read-side pattern checker: reads one frame, compares it with the
// generator pattern, reports errors. Optional watchdog: `define DATA_CHK_TIMEOUT_EN.
module vga_data_chk #(
    parameter int  DATA_DEPTH  = 1024*240,
    parameter int  ERR_CNT_W   = 16,
    parameter int  TIMEOUT_CYC = 4096,
    localparam int ADDR_W      = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
    localparam int CNT_W       = $clog2(DATA_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    vga_data_chk_if.master        rd,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [7:0]            frame_cnt,
    output logic                  timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(DATA_DEPTH - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

    state_t                 state_r, state_nxt_s;
    logic [CNT_W-1:0]       req_cnt_r, rcv_cnt_r;
    logic [ERR_CNT_W-1:0]   err_cnt_r;
    logic [ADDR_W-1:0]      first_err_addr_r;
    logic                   err_seen_r, pass_r, done_r, timeout_r;
    logic [7:0]             frame_cnt_r;
    logic                   acc_s, vld_s, mism_s, last_req_s, last_rcv_s, wd_fire_s;

    // Pattern written by the frame generator: word index xor frame seed.
    function automatic logic [15:0] exp_word(input logic [CNT_W-1:0] idx,
                                             input logic [7:0]       seed);
        logic [31:0] w;
        w = 32'(idx);
        return w[15:0] ^ {seed, 8'h00};
    endfunction

`ifdef DATA_CHK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt_r;

    assign wd_fire_s = (state_r != ST_IDLE) && !acc_s && !vld_s &&
                       (wd_cnt_r == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog: consecutive busy cycles without an accepted request or data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if ((state_r == ST_IDLE) || acc_s || vld_s) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1'b1);
        end
    end
`else
    assign wd_fire_s = 1'b0;
`endif

    // Handshake decode and next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        acc_s       = (state_r == ST_REQ) && rd.rd_rdy;
        vld_s       = (state_r != ST_IDLE) && rd.din_vld;
        last_req_s  = acc_s && (req_cnt_r == LAST_IDX);
        last_rcv_s  = vld_s && (rcv_cnt_r == LAST_IDX);
        mism_s      = vld_s && (rd.din != exp_word(rcv_cnt_r, frame_cnt_r));
        case (state_r)
            ST_IDLE: begin
                if (start_i) state_nxt_s = ST_REQ;
                else         state_nxt_s = ST_IDLE;
            end
            ST_REQ: begin
                if (last_rcv_s || wd_fire_s) state_nxt_s = ST_IDLE;
                else if (last_req_s)         state_nxt_s = ST_DRAIN;
                else                         state_nxt_s = ST_REQ;
            end
            ST_DRAIN: begin
                if (last_rcv_s || wd_fire_s) state_nxt_s = ST_IDLE;
                else                         state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, counters and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            req_cnt_r        <= {CNT_W{1'b0}};
            rcv_cnt_r        <= {CNT_W{1'b0}};
            err_cnt_r        <= {ERR_CNT_W{1'b0}};
            first_err_addr_r <= {ADDR_W{1'b0}};
            err_seen_r       <= 1'b0;
            pass_r           <= 1'b0;
            done_r           <= 1'b0;
            timeout_r        <= 1'b0;
            frame_cnt_r      <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= 1'b0;
            if ((state_r == ST_IDLE) && start_i) begin
                req_cnt_r        <= {CNT_W{1'b0}};
                rcv_cnt_r        <= {CNT_W{1'b0}};
                err_cnt_r        <= {ERR_CNT_W{1'b0}};
                first_err_addr_r <= {ADDR_W{1'b0}};
                err_seen_r       <= 1'b0;
                pass_r           <= 1'b0;
                timeout_r        <= 1'b0;
            end else begin
                if (acc_s) req_cnt_r <= req_cnt_r + CNT_W'(1'b1);
                if (vld_s) rcv_cnt_r <= rcv_cnt_r + CNT_W'(1'b1);
                if (mism_s) begin
                    if (err_cnt_r != ERR_MAX) err_cnt_r <= err_cnt_r + ERR_CNT_W'(1'b1);
                    if (!err_seen_r) begin
                        first_err_addr_r <= ADDR_W'(rcv_cnt_r);
                        err_seen_r       <= 1'b1;
                    end
                end
                // Completion and watchdog abort both close the frame.
                if (last_rcv_s || wd_fire_s) begin
                    done_r      <= 1'b1;
                    pass_r      <= !(err_seen_r || mism_s) && !wd_fire_s;
                    timeout_r   <= wd_fire_s;
                    frame_cnt_r <= frame_cnt_r + 8'd1;
                end
            end
        end
    end

    assign rd.rd_req      = (state_r == ST_REQ);
    assign busy           = (state_r != ST_IDLE);
    assign done           = done_r;
    assign pass           = pass_r;
    assign err_cnt        = err_cnt_r;
    assign first_err_addr = first_err_addr_r;
    assign frame_cnt      = frame_cnt_r;
    assign timeout        = timeout_r;

endmodule

// File: tb/tb_vga_data_chk.sv
// Randomized bench for vga_data_chk: an in-order arbiter model with variable
// latency and backpressure, checked against a per-frame scoreboard.
`timescale 1ns/1ps
module tb_vga_data_chk;
    localparam int DEPTH  = 16;
    localparam int ECW    = 2;
    localparam int TO_CYC = 32;
    localparam int AW     = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start_i;
    logic           busy, done, pass, timeout;
    logic [ECW-1:0] err_cnt;
    logic [AW-1:0]  first_err_addr;
    logic [7:0]     frame_cnt;

    vga_data_chk_if bus();

    vga_data_chk #(.DATA_DEPTH(DEPTH), .ERR_CNT_W(ECW), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .rd(bus.master),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr), .frame_cnt(frame_cnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int fc_m  = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int idx, input int fc);
        return 16'(idx) ^ {8'(fc), 8'h00};
    endfunction

    function automatic int sat(input int n);
        return (n > (1 << ECW) - 1) ? (1 << ECW) - 1 : n;
    endfunction

    // One frame: start pulse, then arbiter model until done (or a mid-frame reset).
    task automatic run_frame(input int rdy_pct, input int lat, input logic [DEPTH-1:0] err_mask,
                             input int stop_after, input int start_mid, input int rst_at);
        int due_q[$];
        int cyc = 0, nreq = 0, nret = 0, errs = 0, first = -1, last_act = 0;
        bit fin = 1'b0;
        bit exp_to;
        start_i = 1'b1;
        while (!fin) begin
            @(negedge clk);
            start_i = (cyc == start_mid) ? 1'b1 : 1'b0;
            if (done === 1'b1) begin
                exp_to = (nret < DEPTH);
                chk_val("pass", pass, (errs == 0 && !exp_to) ? 1 : 0);
                chk_val("err_cnt_end", err_cnt, sat(errs));
                chk_val("first_err_end", first_err_addr, (first < 0) ? 0 : first);
                chk_val("frame_cnt", frame_cnt, (fc_m + 1) % 256);
                chk_val("busy_end", busy, 0);
                chk_val("timeout", timeout, exp_to);
                chk_val("req_count", nreq, DEPTH);
                if (exp_to) chk_val("timeout_cycle", cyc, last_act + TO_CYC + 1);
                fc_m = (fc_m + 1) % 256;
                bus.din_vld = 1'b0;
                bus.rd_rdy  = 1'b0;
                fin = 1'b1;
            end else begin
                chk_val("busy_run", busy, 1);
                chk_val("err_cnt_run", err_cnt, sat(errs));
                chk_val("first_err_run", first_err_addr, (first < 0) ? 0 : first);
                chk_val("rd_req", bus.rd_req, (nreq < DEPTH) ? 1 : 0);
                if (cyc == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk_val("rst_busy", busy, 0);
                    chk_val("rst_rd_req", bus.rd_req, 0);
                    chk_val("rst_done", done, 0);
                    chk_val("rst_pass", pass, 0);
                    chk_val("rst_err_cnt", err_cnt, 0);
                    chk_val("rst_first_err", first_err_addr, 0);
                    chk_val("rst_frame_cnt", frame_cnt, 0);
                    chk_val("rst_timeout", timeout, 0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    for (int k = 0; k < 6; k++) begin
                        bus.din_vld = 1'b1;
                        bus.din     = 16'hDEAD ^ 16'(k);
                        @(negedge clk);
                    end
                    bus.din_vld = 1'b0;
                    chk_val("late_busy", busy, 0);
                    chk_val("late_err_cnt", err_cnt, 0);
                    chk_val("late_frame_cnt", frame_cnt, 0);
                    chk_val("late_done", done, 0);
                    fc_m = 0;
                    fin = 1'b1;
                end else begin
                    bus.rd_rdy = ($urandom_range(99) < rdy_pct);
                    if (bus.rd_req && bus.rd_rdy) begin
                        due_q.push_back(cyc + lat);
                        nreq++;
                        last_act = cyc;
                    end
                    if (due_q.size() > 0 && due_q[0] <= cyc && nret < stop_after) begin
                        bus.din_vld = 1'b1;
                        bus.din     = pat(nret, fc_m) ^ (err_mask[nret] ? 16'h5A5A : 16'h0000);
                        if (err_mask[nret]) begin
                            errs++;
                            if (first < 0) first = nret;
                        end
                        void'(due_q.pop_front());
                        nret++;
                        last_act = cyc;
                    end else begin
                        bus.din_vld = 1'b0;
                        bus.din     = 16'($urandom);
                    end
                end
            end
            cyc++;
            if (!fin && cyc > 3000) begin
                chk_val("done_wait", 0, 1);
                bus.din_vld = 1'b0;
                bus.rd_rdy  = 1'b0;
                fin = 1'b1;
            end
        end
    endtask

    initial begin
        logic [DEPTH-1:0] mask;
        rst_n = 1'b0; start_i = 1'b0;
        bus.rd_rdy = 1'b0; bus.din = 16'h0000; bus.din_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk_val("reset_busy", busy, 0);
        chk_val("reset_rd_req", bus.rd_req, 0);
        chk_val("reset_done", done, 0);
        chk_val("reset_pass", pass, 0);
        chk_val("reset_timeout", timeout, 0);
        chk_val("reset_err_cnt", err_cnt, 0);
        chk_val("reset_first_err", first_err_addr, 0);
        chk_val("reset_frame_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            bus.din_vld = 1'b1;
            bus.din     = 16'($urandom) | 16'h8000;
            @(negedge clk);
        end
        bus.din_vld = 1'b0;
        chk_val("idle_vld_err_cnt", err_cnt, 0);
        chk_val("idle_vld_busy", busy, 0);
        chk_val("idle_vld_done", done, 0);

        run_frame(100, 3, 16'h0000, DEPTH, -1, -1);   // clean frame 0
        run_frame(50, 2, 16'h0000, DEPTH, 4, -1);     // start while busy
        run_frame(50, 4, 16'h0000, DEPTH, -1, -1);    // frame 2, seed 0x0200
        run_frame(100, 3, 16'h0003, DEPTH, -1, 10);   // mid-frame reset
        run_frame(100, 3, 16'h0220, DEPTH, -1, -1);   // words 5 and 9 wrong
        run_frame(70, 1, 16'hFFFF, DEPTH, -1, -1);    // error counter saturates
`ifdef DATA_CHK_TIMEOUT_EN
        run_frame(100, 3, 16'h0000, 7, -1, -1);       // data stops after word 7
`endif
        for (int f = 0; f < 256; f++) begin
            mask = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom & $urandom);
            run_frame($urandom_range(100, 30), $urandom_range(5, 1), mask, DEPTH, -1, -1);
        end
        @(negedge clk);
        chk_val("wrap_frame_cnt", frame_cnt, fc_m);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/vga_data_chk.md
# vga_data_chk

Read-side pattern checker for the SDRAM frame buffer: on a start pulse it reads one frame of DATA_DEPTH 16-bit words through the memory arbiter's read port and compares each word against the pattern that the frame generator writes. It counts mismatches, captures the first failing address, and reports pass/fail per frame. It sits on the arbiter read port in place of, or time-shared with, the VGA scan-out. It is the bring-up and regression check for the write path.

## Interface
- DATA_DEPTH, 1024*240: words per frame to read and check.
- ERR_CNT_W, 16: width of the error counter; the counter saturates at all-ones.
- TIMEOUT_CYC, 4096: watchdog limit in idle cycles. Used only with DATA_CHK_TIMEOUT_EN.

- clk  in  1  single clock. Sampled on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse that starts checking a frame.
- rd_rdy  in  1  arbiter can accept a read request this cycle.
- rd_req  out  1  read request. A word is requested on each cycle where rd_req && rd_rdy.
- din  in  16  read data from the arbiter.
- din_vld  in  1  din is valid. Data returns in request order, with arbitrary latency.
- busy  out  1  a frame check is in progress.
- done  out  1  one-cycle pulse at the end of a check.
- pass  out  1  last check finished with zero errors and no timeout.
- err_cnt  out  ERR_CNT_W  mismatches counted in the last or current frame.
- first_err_addr  out  clog2(DATA_DEPTH)  word index of the first mismatch.
- frame_cnt  out  8  number of completed checks. Also selects the pattern seed.
- timeout  out  1  last check was aborted by the watchdog.

## Operation
- States:
  - IDLE: wait for start_i.
  - REQ: issue read requests.
  - DRAIN: all words requested; wait for the remaining data.
  - Return to IDLE at completion.
- IDLE → REQ on start_i:
  - Clear req_cnt, rcv_cnt, err_cnt, first_err_addr, pass and timeout.
  - Set busy.
- REQ:
  - rd_req is 1.
  - req_cnt increments on each rd_req && rd_rdy.
  - When req_cnt reaches DATA_DEPTH: go to DRAIN and drop rd_req.
- Compare in REQ or DRAIN:
  - Expected word is exp = rcv_cnt[15:0] ^ {frame_cnt, 8'h00}. Arithmetic is 16-bit with wrap.
  - On each din_vld, compare din against exp and increment rcv_cnt.
  - On mismatch, err_cnt increments, saturating at 2^ERR_CNT_W−1.
  - On the first mismatch of the frame only, first_err_addr ← rcv_cnt.
- Completion, when rcv_cnt reaches DATA_DEPTH:
  - Go to IDLE and clear busy.
  - Pulse done.
  - pass ← (no mismatch in the frame).
  - frame_cnt increments, wrapping 255 → 0.
- rcv_cnt may overtake req_cnt transitions: din_vld is accepted while in REQ.
- start_i while busy is ignored.
- din_vld while in IDLE is ignored and has no effect on any counter.
- err_cnt, first_err_addr, pass and timeout hold their values until the next accepted start_i.
- Reset mid-frame returns all state to reset values immediately. Read data still in flight afterwards arrives while in IDLE and is ignored.

## Timing
- Reset values:
  - rd_req, busy, done, pass, timeout = 0.
  - err_cnt, first_err_addr, frame_cnt = 0.
  - State is IDLE.
- rd_req and busy are decoded from registers only. There is no combinational path from rd_rdy, din_vld or start_i to any output.
- start_i is sampled at edge E. busy and rd_req are high from E+1.
- When the last request is accepted at edge R, rd_req is low from R+1.
- din_vld is sampled at edge V. err_cnt and first_err_addr reflect that word from V+1.
- When the final word is sampled at edge F:
  - done is high for the cycle F..F+1 only.
  - pass, frame_cnt and busy = 0 are valid from F+1.
- A start_i in the same cycle that done is high is accepted, because the state is IDLE at that edge.
- DATA_DEPTH = 1 is legal: exactly one request and one compare.

## Configuration
- DATA_CHK_TIMEOUT_EN defined:
  - A watchdog counts consecutive cycles in REQ or DRAIN with no request accepted and no din_vld.
  - At TIMEOUT_CYC it aborts: return to IDLE, set timeout = 1 and pass = 0, pulse done, and increment frame_cnt.
  - Any progress clears the watchdog.
- DATA_CHK_TIMEOUT_EN undefined:
  - No watchdog logic.
  - timeout is tied to 0.
  - The checker waits indefinitely for data.

## Test plan
- Clean frame: DATA_DEPTH = 16, rd_rdy held 1, model returns the correct pattern with 3-cycle latency → done after the 16th word, pass = 1, err_cnt = 0, frame_cnt = 1.
- Injected errors: corrupt words 5 and 9 of frame 0 → err_cnt = 2, first_err_addr = 5, pass = 0.
- Backpressure and seed: random rd_rdy (50%), frame 2, pattern seeded with 0x0200 → exactly 16 accepted requests, pass = 1, frame_cnt = 3.
- Saturation and wrap: ERR_CNT_W = 2 with all 16 words wrong → err_cnt = 3. Run 256 frames → frame_cnt wraps to 0.
- Start while busy and mid-frame reset: start_i during REQ has no effect. Assert rst_n low mid-frame → all outputs 0; late din_vld arrives while in IDLE and is ignored.
- DATA_CHK_TIMEOUT_EN with TIMEOUT_CYC = 32: stop returning data after word 7 → done 32 cycles after the last activity, timeout = 1, pass = 0.
